calc_req_router: RTL

- Parametrised N-channel request router between testbench-facing request channels and the single command port of the calculator DUT wrapper.
- Round-robin arbitration of channel requests onto one registered downstream port; each request is tagged with {channel, sequence}.
- Per-channel outstanding-request counts are tracked, and tagged DUT responses are routed back to the owning channel.
- Sits between the tb interface and the DUT wrapper; generalises the current single-channel hookup to NUM_CH channels.

---
 rtl/calc_req_router_if.sv | 45 ++++
 rtl/calc_req_router.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/calc_req_router_if.sv
// Request/response bus bundle for calc_req_router: upstream channels, downstream
// command port, DUT response port and per-channel routed responses.
interface calc_req_router_if #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int MAX_OUT = 4
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SEQ_W = $clog2(MAX_OUT);
  localparam int TAG_W = CH_W + SEQ_W;

  logic [NUM_CH-1:0]        up_valid;
  logic [NUM_CH-1:0]        up_ready;
  logic [NUM_CH*CMD_W-1:0]  up_cmd;
  logic [NUM_CH*DATA_W-1:0] up_op1;
  logic [NUM_CH*DATA_W-1:0] up_op2;

  logic                     dn_valid;
  logic                     dn_ready;
  logic [CMD_W-1:0]         dn_cmd;
  logic [DATA_W-1:0]        dn_op1;
  logic [DATA_W-1:0]        dn_op2;
  logic [TAG_W-1:0]         dn_tag;

  logic                     rs_valid;
  logic [DATA_W-1:0]        rs_data;
  logic [TAG_W-1:0]         rs_tag;

  logic [NUM_CH-1:0]        cr_valid;
  logic [DATA_W-1:0]        cr_data;
  logic [SEQ_W-1:0]         cr_seq;

  // Router side.
  modport slave (
    input  up_valid, up_cmd, up_op1, up_op2, dn_ready, rs_valid, rs_data, rs_tag,
    output up_ready, dn_valid, dn_cmd, dn_op1, dn_op2, dn_tag, cr_valid, cr_data, cr_seq
  );

  // Requester / DUT-wrapper side.
  modport master (
    output up_valid, up_cmd, up_op1, up_op2, dn_ready, rs_valid, rs_data, rs_tag,
    input  up_ready, dn_valid, dn_cmd, dn_op1, dn_op2, dn_tag, cr_valid, cr_data, cr_seq
  );
endinterface

// File: rtl/calc_req_router.sv
// N-channel round-robin request router with tagged response return.
// Optional per-channel watchdog enabled by defining CALC_ROUTER_TIMEOUT_EN.
module calc_req_router #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int CMD_W       = 4,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  calc_req_router_if.slave                     bus,
  output logic [NUM_CH*($clog2(MAX_OUT)+1)-1:0] outstanding,
  output logic                                 err_stray
`ifdef CALC_ROUTER_TIMEOUT_EN
  ,
  output logic [NUM_CH-1:0]                    err_timeout
`endif
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SEQ_W = $clog2(MAX_OUT);
  localparam int TAG_W = CH_W + SEQ_W;
  localparam int CNT_W = SEQ_W + 1;

  if (NUM_CH < 2 || NUM_CH > 8 || MAX_OUT < 2 || (MAX_OUT & (MAX_OUT - 1)) != 0 ||
      TIMEOUT_CYC < 1) begin : g_bad_params
    $error("calc_req_router: illegal parameter set");
  end

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [SEQ_W-1:0]  seq [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;

  logic              dn_valid_q;
  logic [CMD_W-1:0]  dn_cmd_q;
  logic [DATA_W-1:0] dn_op1_q;
  logic [DATA_W-1:0] dn_op2_q;
  logic [TAG_W-1:0]  dn_tag_q;
  logic [NUM_CH-1:0] cr_valid_q;
  logic [DATA_W-1:0] cr_data_q;
  logic [SEQ_W-1:0]  cr_seq_q;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] route_hit;
  logic [CH_W-1:0]   cand;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  logic              or_free;
  logic              accept;
  logic              stray;
  logic [CH_W-1:0]   rs_ch;
  logic [SEQ_W-1:0]  rs_seq;

  assign or_free = !dn_valid_q || bus.dn_ready;
  assign rs_ch   = bus.rs_tag[TAG_W-1:SEQ_W];
  assign rs_seq  = bus.rs_tag[SEQ_W-1:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    elig        = '0;
    route_hit   = '0;
    cand        = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i]      = bus.up_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
      route_hit[i] = bus.rs_valid && (rs_ch == CH_W'(i)) && (cnt[i] != '0);
    end
    // Scan from the round-robin pointer, wrapping past the last channel.
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Grants are suppressed while reset is held so up_ready never advertises a slot.
  assign accept   = rst_n && or_free && grant_found;
  assign grant_oh = accept ? (NUM_CH'(1) << grant_idx) : '0;
  assign stray    = bus.rs_valid && (route_hit == '0);

  assign bus.up_ready = grant_oh;
  assign bus.dn_valid = dn_valid_q;
  assign bus.dn_cmd   = dn_cmd_q;
  assign bus.dn_op1   = dn_op1_q;
  assign bus.dn_op2   = dn_op2_q;
  assign bus.dn_tag   = dn_tag_q;
  assign bus.cr_valid = cr_valid_q;
  assign bus.cr_data  = cr_data_q;
  assign bus.cr_seq   = cr_seq_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign outstanding[g*CNT_W +: CNT_W] = cnt[g];
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_valid_q <= 1'b0;
      dn_cmd_q   <= '0;
      dn_op1_q   <= '0;
      dn_op2_q   <= '0;
      dn_tag_q   <= '0;
      cr_valid_q <= '0;
      cr_data_q  <= '0;
      cr_seq_q   <= '0;
      err_stray  <= 1'b0;
      rr_ptr     <= '0;
      // NOTE: cnt/seq are small flop arrays, not RAM, so they can and must be reset here.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        seq[i] <= '0;
      end
    end else begin
      if (or_free) begin
        dn_valid_q <= accept;
        if (accept) begin
          dn_cmd_q <= bus.up_cmd[grant_idx*CMD_W +: CMD_W];
          dn_op1_q <= bus.up_op1[grant_idx*DATA_W +: DATA_W];
          dn_op2_q <= bus.up_op2[grant_idx*DATA_W +: DATA_W];
          dn_tag_q <= {grant_idx, seq[grant_idx]};
          rr_ptr   <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_oh[i]) begin
          seq[i] <= seq[i] + SEQ_W'(1);
        end
        // A simultaneous issue and return on one channel cancel out.
        if (grant_oh[i] && !route_hit[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (!grant_oh[i] && route_hit[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end

      cr_valid_q <= route_hit;
      if (route_hit != '0) begin
        cr_data_q <= bus.rs_data;
        cr_seq_q  <= rs_seq;
      end
      err_stray <= stray;
    end
  end

`ifdef CALC_ROUTER_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);

  logic [AGE_W-1:0] age [NUM_CH];

  // Age counts only while a channel has work in flight and nothing has come back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_timeout <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        err_timeout[i] <= 1'b0;
        if (cnt[i] == '0 || route_hit[i]) begin
          age[i] <= '0;
        end else if (age[i] == AGE_W'(TIMEOUT_CYC - 1)) begin
          age[i]         <= '0;
          err_timeout[i] <= 1'b1;
        end else begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end
`endif
endmodule
